// File: rtl/lcd_seq_pkg.sv
// Shared types, helpers and the default init ROM for the LCD init sequencer.
package lcd_seq_pkg;

   typedef enum logic [1:0] {
      CMD   = 2'b00,
      DATA  = 2'b01,
      DELAY = 2'b10,
      END   = 2'b11
   } entry_t;

   typedef struct packed {
      entry_t     etype;
      logic [9:0] arg;
   } rom_entry_t;

   function automatic logic [31:0] mk_word(input logic dcn, input logic [7:0] data);
      return {23'b0, dcn, data};
   endfunction

   localparam int unsigned INIT_DEPTH = 16;

   // Typical panel bring-up: reset, wake, pixel format, orientation, display on.
   localparam rom_entry_t [0:INIT_DEPTH-1] INIT_ROM = '{
      '{CMD,   10'h001}, '{DELAY, 10'd150}, '{CMD,   10'h011}, '{DELAY, 10'd255},
      '{CMD,   10'h03a}, '{DATA,  10'h055}, '{CMD,   10'h036}, '{DATA,  10'h000},
      '{CMD,   10'h029}, '{DELAY, 10'd100}, '{END,   10'h000}, '{END,   10'h000},
      '{END,   10'h000}, '{END,   10'h000}, '{END,   10'h000}, '{END,   10'h000}
   };

endpackage

// File: rtl/lcd_init_rom.sv
// Synchronous-read init ROM; data_o reflects addr_i from the previous clock.
module lcd_init_rom
   import lcd_seq_pkg::*;
#(
   parameter int unsigned                    ROM_DEPTH = 16,
   parameter int unsigned                    AW        = $clog2(ROM_DEPTH),
   parameter rom_entry_t [0:ROM_DEPTH-1]     CONTENTS  = INIT_ROM
) (
   input  logic          clk_i,
   input  logic [AW-1:0] addr_i,
   output rom_entry_t    data_o
);

   rom_entry_t data_q;

   always_ff @(posedge clk_i) begin
      data_q <= CONTENTS[addr_i];
   end

   assign data_o = data_q;

endmodule

// File: rtl/lcd_init_sequencer.sv
// Walks the init ROM into the spimaster with enforced byte gaps, then hands the
// write port to the host through a waitrequest handshake.
module lcd_init_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int unsigned                BYTE_GAP   = 40,
   parameter int unsigned                DELAY_UNIT = 1000,
   parameter int unsigned                ROM_DEPTH  = 16,
   parameter rom_entry_t [0:ROM_DEPTH-1] ROM_INIT   = INIT_ROM
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        h_write,
   input  logic [31:0] h_writedata,
   output logic        h_waitrequest,
   output logic        init_done,
   output logic        m_write,
   output logic [31:0] m_writedata
);

   localparam int unsigned    PCW     = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
   localparam int unsigned    GW      = $clog2(BYTE_GAP + 1);
   localparam int unsigned    DW      = 10 + $clog2(DELAY_UNIT + 1);
   localparam logic [PCW-1:0] PC_LAST = PCW'(ROM_DEPTH - 1);

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_ISSUE,
      ST_GAP,
      ST_DELAY,
      ST_DONE
   } state_t;

   state_t         state_q;
   logic [PCW-1:0] pc_q;
   logic [GW-1:0]  gap_q;
   logic [DW-1:0]  dly_q;
   logic           hvalid_q;
   logic [8:0]     hword_q;

   rom_entry_t     rom_q;
   logic           rom_byte;
   logic           pc_last;
   logic           accept;
   logic [DW-1:0]  dly_load;
   logic           unused_hwd;

   lcd_init_rom #(
      .ROM_DEPTH (ROM_DEPTH),
      .AW        (PCW),
      .CONTENTS  (ROM_INIT)
   ) u_rom (
      .clk_i  (clk),
      .addr_i (pc_q),
      .data_o (rom_q)
   );

   assign pc_last       = (pc_q == PC_LAST);
   assign dly_load      = DW'(rom_q.arg) * DW'(DELAY_UNIT);
   assign h_waitrequest = !(state_q == ST_DONE && gap_q == '0 && !start);
   assign accept        = h_write && !h_waitrequest;
   assign init_done     = (state_q == ST_DONE);
   assign unused_hwd    = ^h_writedata[31:9];

   // The ROM word only lands on the ISSUE edge, so the ROM strobe is decoded from
   // registered state and ROM data; host words come from their own register.
   assign rom_byte    = (state_q == ST_ISSUE) && (rom_q.etype == CMD || rom_q.etype == DATA);
   assign m_write     = rom_byte || hvalid_q;
   assign m_writedata = rom_byte ? mk_word(rom_q.etype == DATA, rom_q.arg[7:0]) :
                        hvalid_q ? {23'b0, hword_q} : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_FETCH;
         pc_q     <= '0;
         gap_q    <= '0;
         dly_q    <= '0;
         hvalid_q <= 1'b0;
         hword_q  <= '0;
      end else begin
         hvalid_q <= 1'b0;
         unique case (state_q)
            ST_FETCH: state_q <= ST_ISSUE;
            ST_ISSUE: begin
               unique case (rom_q.etype)
                  CMD, DATA: begin
                     gap_q   <= GW'(BYTE_GAP);
                     state_q <= ST_GAP;
                  end
                  DELAY: begin
                     if (rom_q.arg == '0) begin
                        state_q <= pc_last ? ST_DONE : ST_FETCH;
                        pc_q    <= pc_last ? pc_q : pc_q + 1'b1;
                     end else begin
                        dly_q   <= dly_load;
                        state_q <= ST_DELAY;
                     end
                  end
                  END: state_q <= ST_DONE;
               endcase
            end
            ST_GAP: begin
               gap_q <= gap_q - 1'b1;
               if (gap_q <= GW'(1)) begin
                  state_q <= pc_last ? ST_DONE : ST_FETCH;
                  pc_q    <= pc_last ? pc_q : pc_q + 1'b1;
               end
            end
            ST_DELAY: begin
               dly_q <= dly_q - 1'b1;
               if (dly_q <= DW'(1)) begin
                  state_q <= pc_last ? ST_DONE : ST_FETCH;
                  pc_q    <= pc_last ? pc_q : pc_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (start && gap_q == '0) begin
                  state_q <= ST_FETCH;
                  pc_q    <= '0;
               end else if (accept) begin
                  hvalid_q <= 1'b1;
                  hword_q  <= h_writedata[8:0];
                  gap_q    <= GW'(BYTE_GAP);
               end else if (gap_q != '0) begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: state_q <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: a schedule-based model of the write timeline
// checked every cycle, plus literal checkpoints for the directed scenarios.
module tb_lcd_init_sequencer;
   import lcd_seq_pkg::*;

   localparam int unsigned GAP   = 4;
   localparam int unsigned DU    = 3;
   localparam int          NEVER = 1 << 30;

   localparam rom_entry_t [0:15] TB_ROM = '{
      '{CMD,  10'h001}, '{DELAY, 10'd2},  '{CMD,  10'h011}, '{DATA, 10'h0c5},
      '{END,  10'h000}, '{END,  10'h000}, '{END,  10'h000}, '{END,  10'h000},
      '{END,  10'h000}, '{END,  10'h000}, '{END,  10'h000}, '{END,  10'h000},
      '{END,  10'h000}, '{END,  10'h000}, '{END,  10'h000}, '{END,  10'h000}
   };

   logic        clk;
   logic        resetn;
   logic        start;
   logic        h_write;
   logic [31:0] h_writedata;
   logic        h_waitrequest;
   logic        init_done;
   logic        m_write;
   logic [31:0] m_writedata;

   lcd_init_sequencer #(
      .BYTE_GAP   (GAP),
      .DELAY_UNIT (DU),
      .ROM_DEPTH  (16),
      .ROM_INIT   (TB_ROM)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .start         (start),
      .h_write       (h_write),
      .h_writedata   (h_writedata),
      .h_waitrequest (h_waitrequest),
      .init_done     (init_done),
      .m_write       (m_write),
      .m_writedata   (m_writedata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: absolute cycle -> word expected on the spimaster port
   logic [31:0] exp_word [int];
   int  done_from  = NEVER;
   int  ready_from = 0;
   bit  was_rst    = 1'b1;
   bit  prev_mw    = 1'b0;
   bit  done_now, exp_mw, exp_wait;

   // Lays out the init sequence given the cycle its first FETCH occupies.
   function automatic void schedule(input int fetch_cyc);
      int t = fetch_cyc + 1;
      for (int i = 0; i < 16; i++) begin
         if (TB_ROM[i].etype == END) begin
            done_from = t + 1;
            break;
         end else if (TB_ROM[i].etype == DELAY) begin
            t += int'(TB_ROM[i].arg) * DU + 2;
         end else begin
            exp_word[t] = {23'b0, TB_ROM[i].etype == DATA, TB_ROM[i].arg[7:0]};
            t += GAP + 2;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (!resetn) begin
         chk("rst_m_write", m_write, 0);
         chk("rst_m_writedata", m_writedata, 0);
         chk("rst_init_done", init_done, 0);
         chk("rst_waitrequest", h_waitrequest, 1);
         exp_word.delete();
         done_from  = NEVER;
         ready_from = 0;
         prev_mw    = 1'b0;
         was_rst    = 1'b1;
      end else begin
         if (was_rst) begin
            schedule(cyc);
            was_rst = 1'b0;
         end
         done_now = (cyc >= done_from);
         exp_mw   = exp_word.exists(cyc);
         exp_wait = !(done_now && cyc >= ready_from && !start);
         chk("m_write", m_write, exp_mw);
         if (exp_mw) chk("m_writedata", m_writedata, exp_word[cyc]);
         if (m_write) chk("m_write_adjacent", prev_mw, 0);
         chk("init_done", init_done, done_now);
         chk("h_waitrequest", h_waitrequest, exp_wait);
         if (!exp_wait && h_write) begin
            exp_word[cyc + 1] = {23'b0, h_writedata[8:0]};
            ready_from = cyc + 1 + GAP;
         end else if (done_now && start && cyc >= ready_from) begin
            done_from = NEVER;
            schedule(cyc + 1);
         end
         prev_mw = m_write;
      end
   end

   task automatic at_cycle(input int k);
      do @(negedge clk); while (cyc < k);
   endtask

   task automatic host_write(input logic [31:0] d, output int acc_cyc);
      bit ok = 1'b0;
      acc_cyc     = -1;
      h_write     = 1'b1;
      h_writedata = d;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (!h_waitrequest) begin
            ok      = 1'b1;
            acc_cyc = cyc;
         end
      end
      chk("host_accept_in_time", ok, 1);
      @(posedge clk);
      #1 h_write = 1'b0;
   endtask

   int rel, a1, a2, s, t, r2;

   initial begin
      resetn      = 1'b0;
      start       = 1'b0;
      h_write     = 1'b0;
      h_writedata = '0;
      repeat (3) @(posedge clk);
      // Host request held from before release; must wait out the whole init
      h_write     = 1'b1;
      h_writedata = 32'hABCD_E15C;
      #1 resetn = 1'b1;
      rel = cyc;

      at_cycle(rel);
      chk("lit_cycle1_idle", m_write, 0);
      at_cycle(rel + 1);
      chk("lit_first_mw", m_write, 1);
      chk("lit_first_word", m_writedata, 32'h001);
      at_cycle(rel + 4);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      at_cycle(rel + 10);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      at_cycle(rel + 15);
      chk("lit_second_mw", m_write, 1);
      chk("lit_second_word", m_writedata, 32'h011);
      at_cycle(rel + 21);
      chk("lit_third_mw", m_write, 1);
      chk("lit_third_word", m_writedata, 32'h1c5);
      at_cycle(rel + 27);
      chk("lit_done_not_yet", init_done, 0);
      chk("lit_wait_during_init", h_waitrequest, 1);
      at_cycle(rel + 28);
      chk("lit_done_rises", init_done, 1);
      chk("lit_held_accept", h_waitrequest, 0);
      @(posedge clk); #1 h_write = 1'b0;
      at_cycle(rel + 29);
      chk("lit_held_mw", m_write, 1);
      chk("lit_held_word", m_writedata, 32'h15c);

      host_write(32'h0000_005C, a1);
      host_write(32'h1234_51A5, a2);
      chk("lit_b2b_first_accept", a1 - rel, 33);
      chk("lit_b2b_spacing", a2 - a1, GAP + 1);

      at_cycle(a2 + 6);
      @(posedge clk); #1 start = 1'b1;
      @(negedge clk);
      s = cyc;
      chk("lit_start_done_high", init_done, 1);
      chk("lit_start_wait", h_waitrequest, 1);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("lit_start_done_falls", init_done, 0);
      @(negedge clk);
      chk("lit_restart_mw", m_write, 1);
      chk("lit_restart_word", m_writedata, 32'h001);
      at_cycle(s + 16);
      chk("lit_restart_second", m_writedata, 32'h011);
      at_cycle(s + 28);
      chk("lit_redo_not_done", init_done, 0);
      at_cycle(s + 29);
      chk("lit_redo_done", init_done, 1);

      @(posedge clk);
      #1 start = 1'b1; h_write = 1'b1; h_writedata = 32'h0000_00AA;
      @(negedge clk);
      t = cyc;
      chk("lit_start_beats_write", h_waitrequest, 1);
      @(posedge clk); #1 start = 1'b0; h_write = 1'b0;
      @(negedge clk);
      chk("lit_no_host_mw", m_write, 0);
      chk("lit_restart2_done_low", init_done, 0);
      @(negedge clk);
      chk("lit_restart2_mw", m_write, 1);
      chk("lit_restart2_word", m_writedata, 32'h001);

      at_cycle(t + 10);
      @(posedge clk); #1 resetn = 1'b0;
      #1;
      chk("lit_midrst_mw", m_write, 0);
      chk("lit_midrst_word", m_writedata, 0);
      chk("lit_midrst_done", init_done, 0);
      chk("lit_midrst_wait", h_waitrequest, 1);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      r2 = cyc;
      at_cycle(r2);
      chk("lit_rerel_idle", m_write, 0);
      at_cycle(r2 + 1);
      chk("lit_rerel_mw", m_write, 1);
      chk("lit_rerel_word", m_writedata, 32'h001);
      at_cycle(r2 + 28);
      chk("lit_rerel_done", init_done, 1);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus, expected finish before 200000 time units");
      $fatal(1);
   end

endmodule
